// File: rtl/ling_nibble_add_sched_if.sv
// Request/result bundle for the nibble-serial add/subtract scheduler.
// master = requesters and result consumer, slave = the scheduler.
interface ling_nibble_add_sched_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_sub;

    logic             req1_valid;
    logic             req1_ready;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_sub;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_sum;
    logic             res_cout;
    logic             res_id;

    modport master (
        output req0_valid, req0_a, req0_b, req0_sub,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_sub,
        input  req1_ready,
        input  res_valid, res_sum, res_cout, res_id,
        output res_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_sub,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_sub,
        output req1_ready,
        output res_valid, res_sum, res_cout, res_id,
        input  res_ready
    );
endinterface

// File: rtl/ling_nibble_add_sched.sv
// Time-shares one 4-bit Ling adder slice between two requesters, performing
// WIDTH-bit add/subtract least significant nibble first with a registered
// carry between slices. Ties are broken round-robin.
module ling_nibble_add_sched #(
    parameter int WIDTH = 16
) (
    input  logic clk,
    input  logic rst_n,
    ling_nibble_add_sched_if.slave bus
);
    localparam int NIB = WIDTH / 4;
    localparam int KW  = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] op_a, op_b, acc, acc_nxt;
    logic [WIDTH-1:0] res_sum_r;
    logic             res_cout_r, res_id_r;
    logic             carry, own_id, ptr;
    logic [KW-1:0]    k;
    logic             gnt0, gnt1, last_nib;

    logic [WIDTH-1:0] sel_a, sel_b;
    logic             sel_sub;
    logic [WIDTH-1:0] sh_a, sh_b, nib_mask, sum_ext;
    logic [3:0]       slice_sum;
    logic             slice_cout;

    // Ling carry formulation: h[i+1] = g[i] | t[i-1]&h[i], c[i+1] = t[i]&h[i+1],
    // with t[-1] taken as 1 so the incoming carry seeds h[0].
    function automatic logic [4:0] ling_add4(input logic [3:0] a,
                                             input logic [3:0] b,
                                             input logic       cin);
        logic [3:0] g, t, p;
        logic [4:0] h, c;
        g    = a & b;
        t    = a | b;
        p    = a ^ b;
        h    = '0;
        c    = '0;
        h[0] = cin;
        c[0] = cin;
        h[1] = g[0] | h[0];
        c[1] = t[0] & h[1];
        for (int i = 1; i < 4; i++) begin
            h[i+1] = g[i] | (t[i-1] & h[i]);
            c[i+1] = t[i] & h[i+1];
        end
        return {c[4], p ^ c[3:0]};
    endfunction

    assign sh_a     = op_a >> {k, 2'b00};
    assign sh_b     = op_b >> {k, 2'b00};
    assign {slice_cout, slice_sum} = ling_add4(sh_a[3:0], sh_b[3:0], carry);
    assign nib_mask = WIDTH'(4'hF) << {k, 2'b00};
    assign sum_ext  = WIDTH'(slice_sum) << {k, 2'b00};
    assign acc_nxt  = (acc & ~nib_mask) | sum_ext;
    assign last_nib = (k == KW'(NIB - 1));

    assign bus.res_valid = (state == DONE);
    assign bus.res_sum   = res_sum_r;
    assign bus.res_cout  = res_cout_r;
    assign bus.res_id    = res_id_r;

    // Arbitration, operand select and next-state decode.
    always_comb begin
        state_nxt      = state;
        gnt0           = 1'b0;
        gnt1           = 1'b0;
        if (rst_n && state == IDLE) begin
            gnt0 = bus.req0_valid && (!bus.req1_valid || ptr);
            gnt1 = bus.req1_valid && (!bus.req0_valid || !ptr);
        end
        sel_a          = gnt1 ? bus.req1_a   : bus.req0_a;
        sel_b          = gnt1 ? bus.req1_b   : bus.req0_b;
        sel_sub        = gnt1 ? bus.req1_sub : bus.req0_sub;
        bus.req0_ready = gnt0;
        bus.req1_ready = gnt1;
        case (state)
            IDLE:    if (gnt0 || gnt1) state_nxt = RUN;
            RUN:     if (last_nib) state_nxt = DONE;
            DONE:    if (bus.res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Operand capture, per-nibble accumulation and result publication.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a       <= '0;
            op_b       <= '0;
            acc        <= '0;
            carry      <= 1'b0;
            k          <= '0;
            own_id     <= 1'b0;
            ptr        <= 1'b1;
            res_sum_r  <= '0;
            res_cout_r <= 1'b0;
            res_id_r   <= 1'b0;
        end else begin
            if (state == IDLE && (gnt0 || gnt1)) begin
                op_a   <= sel_a;
                op_b   <= sel_sub ? ~sel_b : sel_b;
                carry  <= sel_sub;
                acc    <= '0;
                k      <= '0;
                own_id <= gnt1;
                ptr    <= gnt1;
            end else if (state == RUN) begin
                acc   <= acc_nxt;
                carry <= slice_cout;
                k     <= k + 1'b1;
                if (last_nib) begin
                    k          <= '0;
                    res_sum_r  <= acc_nxt;
                    res_cout_r <= slice_cout;
                    res_id_r   <= own_id;
                end
            end
        end
    end
endmodule
